// File: rtl/cv32e40p_hwloop_ctrl.sv
// cv32e40p_hwloop_ctrl: hardware-loop register file and loop-end controller.
// Holds start/end/count for each of N_HWLP loops. Loop 0 is innermost and wins
// ties. Requests a jump back to the loop start at the loop end, and decrements
// the selected count.
// Optional macro CV32E40P_HWLP_ASSERT_EN compiles concurrent SVA checks.
module cv32e40p_hwloop_ctrl #(
  parameter int N_HWLP      = 2,
  parameter int N_HWLP_BITS = $clog2(N_HWLP)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [2:0]             hwlp_we_i,
  input  logic [N_HWLP_BITS-1:0] hwlp_regid_i,
  input  logic [31:0]            hwlp_start_data_i,
  input  logic [31:0]            hwlp_end_data_i,
  input  logic [31:0]            hwlp_cnt_data_i,
  input  logic [31:0]            pc_id_i,
  input  logic                   id_valid_i,
  output logic                   hwlp_jump_o,
  output logic [31:0]            hwlp_target_o,
  output logic [N_HWLP*32-1:0]   hwlp_start_o,
  output logic [N_HWLP*32-1:0]   hwlp_end_o,
  output logic [N_HWLP*32-1:0]   hwlp_cnt_o
);

  logic [31:0]            start_q [N_HWLP];
  logic [31:0]            end_q   [N_HWLP];
  logic [31:0]            cnt_q   [N_HWLP];
  logic [N_HWLP-1:0]      match;
  logic                   any_match;
  logic [N_HWLP_BITS-1:0] sel;
  logic                   dec_en;

  // Loop-end match per loop, then fixed-priority select (lowest index wins).
  always_comb begin
    match     = '0;
    any_match = 1'b0;
    sel       = '0;
    for (int unsigned i = 0; i < N_HWLP; i++) begin
      match[i] = (pc_id_i == end_q[i]) && (cnt_q[i] != '0);
    end
    // Scan from the outermost down so the innermost match is left in sel.
    for (int unsigned i = N_HWLP; i > 0; i--) begin
      if (match[i-1]) begin
        sel       = N_HWLP_BITS'(i-1);
        any_match = 1'b1;
      end
    end
  end

  assign dec_en        = id_valid_i && any_match;
  assign hwlp_jump_o   = dec_en && (cnt_q[sel] > 32'd1);
  assign hwlp_target_o = any_match ? start_q[sel] : '0;

  // Pack per-loop registers onto the flat output buses.
  always_comb begin
    hwlp_start_o = '0;
    hwlp_end_o   = '0;
    hwlp_cnt_o   = '0;
    for (int unsigned i = 0; i < N_HWLP; i++) begin
      hwlp_start_o[32*i +: 32] = start_q[i];
      hwlp_end_o[32*i +: 32]   = end_q[i];
      hwlp_cnt_o[32*i +: 32]   = cnt_q[i];
    end
  end

  // Register writes; a count write to a loop overrides its decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int unsigned i = 0; i < N_HWLP; i++) begin
        start_q[i] <= '0;
        end_q[i]   <= '0;
        cnt_q[i]   <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < N_HWLP; i++) begin
        if (hwlp_we_i[0] && (hwlp_regid_i == N_HWLP_BITS'(i))) begin
          start_q[i] <= hwlp_start_data_i;
        end
        if (hwlp_we_i[1] && (hwlp_regid_i == N_HWLP_BITS'(i))) begin
          end_q[i] <= hwlp_end_data_i;
        end
        if (hwlp_we_i[2] && (hwlp_regid_i == N_HWLP_BITS'(i))) begin
          cnt_q[i] <= hwlp_cnt_data_i;
        end else if (dec_en && (sel == N_HWLP_BITS'(i))) begin
          cnt_q[i] <= cnt_q[i] - 32'd1;
        end
      end
    end
  end

`ifdef CV32E40P_HWLP_ASSERT_EN
  // Writes must target an existing loop.
  a_regid_range: assert property (@(posedge clk) disable iff (!rst_n)
    (hwlp_we_i != 3'b000) |-> (int'(hwlp_regid_i) < N_HWLP))
    else $error("hwloop: write to out-of-range loop index %0d", hwlp_regid_i);

  // A jump is only ever requested for an accepted instruction.
  a_jump_valid: assert property (@(posedge clk) disable iff (!rst_n)
    hwlp_jump_o |-> id_valid_i)
    else $error("hwloop: jump without id_valid");

  for (genvar g = 0; g < N_HWLP; g++) begin : g_loop_chk
    // Without a count write, a count only holds or drops by exactly one.
    a_dec_step: assert property (@(posedge clk) disable iff (!rst_n)
      !(hwlp_we_i[2] && (hwlp_regid_i == N_HWLP_BITS'(g))) |=>
        ((cnt_q[g] == $past(cnt_q[g])) || (cnt_q[g] == $past(cnt_q[g]) - 32'd1)))
      else $error("hwloop: loop %0d count stepped by more than one", g);

    // An active loop must not end before it starts.
    a_end_ge_start: assert property (@(posedge clk) disable iff (!rst_n)
      (cnt_q[g] != '0) |-> (end_q[g] >= start_q[g]))
      else $error("hwloop: loop %0d end below start", g);
  end
`endif

endmodule

// File: tb/tb_cv32e40p_hwloop_ctrl.sv
// Bench for cv32e40p_hwloop_ctrl: directed steps followed by random traffic,
// all compared against a behavioural loop model held in plain arrays.
module tb_cv32e40p_hwloop_ctrl;
  localparam int N = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [2:0]    we;
  logic          regid;
  logic [31:0]   sd, ed, cd, pc;
  logic          valid;
  logic          jump;
  logic [31:0]   target;
  logic [N*32-1:0] start_o, end_o, cnt_o;

  int checks = 0;
  int errors = 0;

  // Reference state: what each loop register should hold.
  logic [31:0] m_st [N];
  logic [31:0] m_en [N];
  logic [31:0] m_ct [N];

  cv32e40p_hwloop_ctrl #(.N_HWLP(N), .N_HWLP_BITS(1)) dut (
    .clk               (clk),
    .rst_n             (rst_n),
    .hwlp_we_i         (we),
    .hwlp_regid_i      (regid),
    .hwlp_start_data_i (sd),
    .hwlp_end_data_i   (ed),
    .hwlp_cnt_data_i   (cd),
    .pc_id_i           (pc),
    .id_valid_i        (valid),
    .hwlp_jump_o       (jump),
    .hwlp_target_o     (target),
    .hwlp_start_o      (start_o),
    .hwlp_end_o        (end_o),
    .hwlp_cnt_o        (cnt_o)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < N; i++) begin
      m_st[i] = '0; m_en[i] = '0; m_ct[i] = '0;
    end
  endtask

  task automatic chk_regs(input string tag);
    for (int i = 0; i < N; i++) begin
      chk({tag, "_start"}, start_o[32*i +: 32], m_st[i]);
      chk({tag, "_end"},   end_o[32*i +: 32],   m_en[i]);
      chk({tag, "_cnt"},   cnt_o[32*i +: 32],   m_ct[i]);
    end
  endtask

  // One cycle: drive inputs, check the combinational jump, clock, check registers.
  task automatic step(input string tag, input logic [2:0] w, input logic r,
                      input logic [31:0] s, input logic [31:0] e, input logic [31:0] c,
                      input logic [31:0] p, input logic v);
    int hit;
    logic exp_jump;
    logic [31:0] exp_tgt;
    @(negedge clk);
    we = w; regid = r; sd = s; ed = e; cd = c; pc = p; valid = v;
    #1;
    hit = -1;
    for (int i = 0; i < N; i++)
      if (hit < 0 && p == m_en[i] && m_ct[i] != 0) hit = i;
    exp_jump = (hit >= 0) && v && (m_ct[hit] > 1);
    exp_tgt  = (hit >= 0) ? m_st[hit] : 32'h0;
    chk({tag, "_jump"}, {31'b0, jump}, {31'b0, exp_jump});
    chk({tag, "_target"}, target, exp_tgt);
    @(posedge clk);
    if (hit >= 0 && v && !(w[2] && int'(r) == hit)) m_ct[hit] = m_ct[hit] - 1;
    if (w[0]) m_st[r] = s;
    if (w[1]) m_en[r] = e;
    if (w[2]) m_ct[r] = c;
    #1;
    chk_regs(tag);
  endtask

  initial begin
    logic [31:0] rs, re;
    rst_n = 1'b0; we = '0; regid = '0; sd = '0; ed = '0; cd = '0; pc = '0; valid = 1'b0;
    model_clear();
    #12;
    chk("rst_jump", {31'b0, jump}, 32'h0);
    chk("rst_target", target, 32'h0);
    chk_regs("rst");
    @(negedge clk); rst_n = 1'b1;

    // Basic loop: three visits to the loop end.
    step("wr0", 3'b111, 1'b0, 32'h100, 32'h120, 32'd3, 32'h0, 1'b0);
    step("it1", 3'b000, 1'b0, 0, 0, 0, 32'h120, 1'b1);
    step("it2", 3'b000, 1'b0, 0, 0, 0, 32'h120, 1'b1);
    step("it3", 3'b000, 1'b0, 0, 0, 0, 32'h120, 1'b1);
    step("done", 3'b000, 1'b0, 0, 0, 0, 32'h120, 1'b1);

    // Nested loops sharing an end address: inner loop wins.
    step("n0", 3'b110, 1'b0, 0, 32'h140, 32'd2, 32'h0, 1'b0);
    step("n1", 3'b111, 1'b1, 32'h200, 32'h140, 32'd5, 32'h0, 1'b0);
    step("nest", 3'b000, 1'b0, 0, 0, 0, 32'h140, 1'b1);

    // id_valid low holds everything; raising it then steps.
    step("c4", 3'b100, 1'b0, 0, 0, 32'd4, 32'h0, 1'b0);
    step("novalid", 3'b000, 1'b0, 0, 0, 0, 32'h140, 1'b0);
    step("valid", 3'b000, 1'b0, 0, 0, 0, 32'h140, 1'b1);

    // Count write colliding with a decrement.
    step("l1e", 3'b110, 1'b1, 0, 32'h300, 32'd7, 32'h0, 1'b0);
    step("wrwin", 3'b100, 1'b1, 0, 0, 32'd10, 32'h300, 1'b1);
    step("l1c7", 3'b100, 1'b1, 0, 0, 32'd7, 32'h0, 1'b0);
    step("other", 3'b100, 1'b0, 0, 0, 32'd9, 32'h300, 1'b1);
    // Start write to the matching loop: jump uses the old start.
    step("oldst", 3'b001, 1'b1, 32'h280, 0, 0, 32'h300, 1'b1);
    // Zero count disables the loop.
    step("zero", 3'b100, 1'b1, 0, 0, 32'd0, 32'h0, 1'b0);
    step("off", 3'b000, 1'b0, 0, 0, 0, 32'h300, 1'b1);

    // Random traffic, biased toward hitting loop ends.
    for (int n = 0; n < 400; n++) begin
      logic [2:0] w;
      logic r;
      logic [31:0] p;
      w  = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(1, 7)) : 3'b000;
      r  = 1'($urandom);
      rs = 32'($urandom_range(0, 255)) << 2;
      re = rs + (32'($urandom_range(1, 64)) << 2);
      p  = ($urandom_range(0, 3) != 0) ? m_en[$urandom_range(0, N-1)] : (32'($urandom_range(0, 511)) << 2);
      step("rnd", w, r, rs, re, 32'($urandom_range(0, 4)), p, ($urandom_range(0, 3) != 0));
    end

    // Asynchronous reset in the middle of an active loop.
    step("ar_wr", 3'b111, 1'b0, 32'h100, 32'h120, 32'd3, 32'h0, 1'b0);
    @(negedge clk);
    we = '0; pc = 32'h120; valid = 1'b1;
    #1;
    chk("ar_pre_jump", {31'b0, jump}, 32'h1);
    #1;
    rst_n = 1'b0;
    #1;
    model_clear();
    chk("ar_jump", {31'b0, jump}, 32'h0);
    chk("ar_target", target, 32'h0);
    chk_regs("ar");
    rst_n = 1'b1;
    step("post1", 3'b000, 1'b0, 0, 0, 0, 32'h120, 1'b1);
    step("post2", 3'b000, 1'b0, 0, 0, 0, 32'h0, 1'b1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
